// File: rtl/grid_scan_if.sv
// grid_scan_if: input stream, grid-memory write port, scan request and hit response bundle
interface grid_scan_if #(parameter int ADDR_W = 16);
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_done;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic              scan_valid;
    logic              scan_ready;
    logic [ADDR_W-1:0] scan_addr;
    logic [ADDR_W-1:0] scan_stride;
    logic [15:0]       scan_x;
    logic [15:0]       scan_y;
    logic              hit_valid;
    logic              hit;
    logic [15:0]       grid_w;
    logic [15:0]       grid_h;
    logic [63:0]       result;
    logic              result_valid;
    logic              busy;
    logic              err_overflow;
    modport master (
        input  in_byte, in_valid, in_done, scan_ready, hit_valid, hit,
        output mem_we, mem_waddr, mem_wdata, scan_valid, scan_addr, scan_stride, scan_x, scan_y,
               grid_w, grid_h, result, result_valid, busy, err_overflow
    );
    modport slave (
        output in_byte, in_valid, in_done, scan_ready, hit_valid, hit,
        input  mem_we, mem_waddr, mem_wdata, scan_valid, scan_addr, scan_stride, scan_x, scan_y,
               grid_w, grid_h, result, result_valid, busy, err_overflow
    );
endinterface

// File: rtl/grid_scan_ctrl.sv
// grid_scan_ctrl: loads a character grid, then issues a scan request per interior cell and totals hits
module grid_scan_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int MAX_OUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    grid_scan_if.master bus
);
    typedef enum logic [1:0] {LOAD, SCAN, DRAIN, DONE} state_t;
    localparam logic [3:0] MAX_Q = 4'(MAX_OUT);
    state_t            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic [15:0]       w_q, w_d, h_q, h_d, x_q, x_d, y_q, y_d, w_fin, h_fin;
    logic [ADDR_W-1:0] base_q, base_d, stride;
    logic [3:0]        out_q, out_d;
    logic [63:0]       res_q, res_d;
    logic              seen_nl_q, seen_nl_d, last_nl_q, last_nl_d, rv_q, rv_d, ovf_q, ovf_d;
    logic              wr, acc, hv, scan_v;
    assign stride = ADDR_W'(w_q) + 1'b1;
    assign scan_v = state_q == SCAN && out_q < MAX_Q;
    assign wr     = state_q == LOAD && bus.in_valid && !ptr_q[ADDR_W] && !rst;
    assign acc    = scan_v && bus.scan_ready;
    assign hv     = (state_q == SCAN || state_q == DRAIN) && bus.hit_valid && out_q != 4'd0;
    // next-state: grid load and dimension learning, raster walk, outstanding tracking, hit totals
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        w_d       = w_q;
        h_d       = h_q;
        x_d       = x_q;
        y_d       = y_q;
        base_d    = base_q;
        res_d     = res_q;
        seen_nl_d = seen_nl_q;
        last_nl_d = last_nl_q;
        rv_d      = rv_q;
        ovf_d     = ovf_q;
        w_fin     = w_q;
        h_fin     = h_q;
        out_d     = out_q + {3'd0, acc} - {3'd0, hv};
        if (state_q == LOAD) begin
            if (bus.in_valid && ptr_q[ADDR_W]) begin
                state_d = DONE;
                ovf_d   = 1'b1;
                rv_d    = 1'b1;
            end else begin
                if (wr) begin
                    ptr_d     = ptr_q + 1'b1;
                    last_nl_d = bus.in_byte == 8'h0a;
                    if (bus.in_byte == 8'h0a) begin
                        h_d = h_q + 16'd1;
                        if (!seen_nl_q) begin
                            w_d       = 16'(ptr_q);
                            seen_nl_d = 1'b1;
                        end
                    end
                end
                if (bus.in_done) begin
                    w_fin = seen_nl_d ? w_d : 16'(ptr_d);
                    h_fin = h_d + ((!last_nl_d && ptr_d != '0) ? 16'd1 : 16'd0);
                    w_d   = w_fin;
                    h_d   = h_fin;
                    if (w_fin < 16'd3 || h_fin < 16'd3) begin
                        state_d = DONE;
                        rv_d    = 1'b1;
                    end else begin
                        state_d = SCAN;
                        x_d     = 16'd1;
                        y_d     = 16'd1;
                        base_d  = ADDR_W'(w_fin) + 1'b1;
                    end
                end
            end
        end
        if (acc) begin
            if (x_q == w_q - 16'd2) begin
                x_d    = 16'd1;
                y_d    = y_q + 16'd1;
                base_d = base_q + stride;
                if (y_q == h_q - 16'd2) state_d = DRAIN;
            end else begin
                x_d = x_q + 16'd1;
            end
        end
        if (hv) res_d = res_q + {63'd0, bus.hit};
        if (state_q == DRAIN && out_q == 4'd0) begin
            state_d = DONE;
            rv_d    = 1'b1;
        end
    end
    // state register; reset aborts everything and returns to LOAD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LOAD;
            ptr_q     <= '0;
            w_q       <= '0;
            h_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            base_q    <= '0;
            out_q     <= '0;
            res_q     <= '0;
            seen_nl_q <= 1'b0;
            last_nl_q <= 1'b0;
            rv_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            w_q       <= w_d;
            h_q       <= h_d;
            x_q       <= x_d;
            y_q       <= y_d;
            base_q    <= base_d;
            out_q     <= out_d;
            res_q     <= res_d;
            seen_nl_q <= seen_nl_d;
            last_nl_q <= last_nl_d;
            rv_q      <= rv_d;
            ovf_q     <= ovf_d;
        end
    end
    assign bus.mem_we       = wr;
    assign bus.mem_waddr    = ptr_q[ADDR_W-1:0];
    assign bus.mem_wdata    = wr ? bus.in_byte : 8'd0;
    assign bus.scan_valid   = scan_v;
    assign bus.scan_addr    = base_q + ADDR_W'(x_q);
    assign bus.scan_stride  = state_q == LOAD ? '0 : stride;
    assign bus.scan_x       = x_q;
    assign bus.scan_y       = y_q;
    assign bus.grid_w       = w_q;
    assign bus.grid_h       = h_q;
    assign bus.result       = res_q;
    assign bus.result_valid = rv_q;
    assign bus.busy         = !rst && state_q != DONE;
    assign bus.err_overflow = ovf_q;
endmodule

// File: tb/tb_grid_scan_ctrl.sv
// tb_grid_scan_ctrl: randomized grids against a string-level model, with a latency/backpressure engine
module tb_grid_scan_ctrl;
    typedef struct packed {logic [15:0] a, s, x, y;} req_t;
    logic clk = 1'b0, rst0 = 1'b1, rst1 = 1'b1;
    int nvec = 0, nerr = 0;
    grid_scan_if #(.ADDR_W(16)) if0 ();
    grid_scan_if #(.ADDR_W(4)) if1 ();
    grid_scan_ctrl #(.ADDR_W(16), .MAX_OUT(4)) u0 (.clk(clk), .rst(rst0), .bus(if0));
    grid_scan_ctrl #(.ADDR_W(4), .MAX_OUT(4)) u1 (.clk(clk), .rst(rst1), .bus(if1));
    always #5 clk = ~clk;

    logic [7:0]  grid[$];
    req_t        got[$];
    logic [23:0] wlog[$];
    int          pend_due[$];
    bit          pend_h[$];
    int cyc = 0, n_acc = 0, n_resp = 0, inflight = 0, lat = 1, rmode = 0, hmode = 0;
    int viol = 0, stall_err = 0, throttle = 0, sv_seen = 0, exp_hits = 0, w1 = 0, sv1 = 0;
    bit stalled = 0, h = 0;
    req_t cur, prev;

    // match-engine stand-in: random ready, fixed-latency in-order responses, request log
    always @(negedge clk) begin
        if (rst0) begin
            pend_due.delete(); pend_h.delete(); got.delete(); wlog.delete();
            n_acc = 0; n_resp = 0; exp_hits = 0; viol = 0; stall_err = 0;
            throttle = 0; sv_seen = 0; stalled = 0;
            if0.hit_valid = 0; if0.hit = 0; if0.scan_ready = 0;
        end else begin
            cyc++;
            inflight = n_acc - n_resp;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                if0.hit_valid = 1;
                if0.hit = pend_h.pop_front();
                void'(pend_due.pop_front());
                n_resp++;
            end else begin
                if0.hit_valid = 0;
                if0.hit = 0;
            end
            if0.scan_ready = rmode != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (if0.mem_we) wlog.push_back({if0.mem_waddr, if0.mem_wdata});
            if (if0.scan_valid) begin
                sv_seen++;
                cur = {if0.scan_addr, if0.scan_stride, if0.scan_x, if0.scan_y};
                if (inflight >= 4) viol++;
                if (stalled && cur != prev) stall_err++;
                if (if0.scan_ready) begin
                    got.push_back(cur);
                    h = hmode == 0 ? 1'b1 : hmode == 1 ? (n_acc % 2 == 0) : 1'($urandom_range(0, 1));
                    exp_hits += int'(h);
                    pend_due.push_back(cyc + lat);
                    pend_h.push_back(h);
                    n_acc++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    prev = cur;
                end
            end else if (inflight == 4) throttle++;
        end
    end

    // write/scan monitor for the small-memory instance
    always @(negedge clk) begin
        #1;
        if (rst1) begin
            w1 = 0;
            sv1 = 0;
        end else begin
            if (if1.mem_we) w1++;
            if (if1.scan_valid) sv1++;
        end
    end

    task automatic set_str(input string s);
        grid.delete();
        for (int i = 0; i < s.len(); i++) grid.push_back(s[i]);
    endtask

    task automatic make_grid(input int w, input int hh, input bit trail);
        grid.delete();
        for (int r = 0; r < hh; r++) begin
            for (int c = 0; c < w; c++) grid.push_back(8'($urandom_range(65, 90)));
            if (r < hh - 1 || trail) grid.push_back(8'h0a);
        end
    endtask

    // reference: W = chars before first newline (or all), H = newline count plus an unterminated last row
    task automatic model(output int W, output int H);
        W = -1;
        H = 0;
        foreach (grid[i]) if (grid[i] == 8'h0a) begin
            if (W < 0) W = i;
            H++;
        end
        if (W < 0) W = grid.size();
        if (grid.size() > 0 && grid[grid.size() - 1] != 8'h0a) H++;
    endtask

    function automatic int req_bad(input int W, input int H);
        int k = 0, bad = 0;
        req_t e;
        for (int y = 1; y <= H - 2; y++)
            for (int x = 1; x <= W - 2; x++) begin
                e = {16'(y * (W + 1) + x), 16'(W + 1), 16'(x), 16'(y)};
                if (k >= got.size() || got[k] !== e) bad++;
                k++;
            end
        return bad + (got.size() > k ? got.size() - k : 0);
    endfunction

    task automatic start0(input int l, input int r, input int hm);
        @(negedge clk);
        rst0 = 1; lat = l; rmode = r; hmode = hm;
        repeat (2) @(negedge clk);
        rst0 = 0;
    endtask

    task automatic load0(input bit with_last);
        for (int i = 0; i < grid.size(); i++) begin
            @(negedge clk);
            if0.in_valid = 1;
            if0.in_byte = grid[i];
            if0.in_done = with_last && i == grid.size() - 1;
        end
        @(negedge clk);
        if0.in_valid = 0;
        if0.in_done = !with_last;
        if (!with_last) begin
            @(negedge clk);
            if0.in_done = 0;
        end
    endtask

    task automatic wait_done(output bit to);
        int n = 0;
        while (if0.result_valid !== 1'b1 && n < 3000) begin
            @(negedge clk); #2; n++;
        end
        to = if0.result_valid !== 1'b1;
    endtask

    task automatic test_reset();
        rst0 = 1; rst1 = 1;
        if0.in_valid = 1; if0.in_byte = 8'h41;
        repeat (2) @(negedge clk);
        #2;
        nvec++; if (if0.busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", if0.busy); end
        nvec++; if (if0.mem_we !== 1'b0) begin nerr++; $display("FAIL reset_mem_we got %b want 0", if0.mem_we); end
        nvec++; if ({if0.result_valid, if0.err_overflow, if0.scan_valid} !== 3'b0) begin nerr++; $display("FAIL reset_flags got %b want 000", {if0.result_valid, if0.err_overflow, if0.scan_valid}); end
        nvec++; if ({if0.result, if0.grid_w, if0.scan_stride, if0.scan_addr} !== '0) begin nerr++; $display("FAIL reset_values result=%0d w=%0d stride=%0d addr=%0d want 0", if0.result, if0.grid_w, if0.scan_stride, if0.scan_addr); end
        @(negedge clk);
        if0.in_valid = 0;
        rst0 = 0; rst1 = 0;
        #2;
        nvec++; if ({if0.busy, if1.busy} !== 2'b11) begin nerr++; $display("FAIL busy_after_reset got %b want 11", {if0.busy, if1.busy}); end
    endtask

    task automatic test_small();
        int W, H, bad;
        bit to;
        set_str("M.S\n.A.\nM.S\n");
        start0(1, 0, 0);
        load0(1);
        wait_done(to);
        model(W, H);
        bad = 0;
        foreach (wlog[i]) if (i >= grid.size() || wlog[i] !== {16'(i), grid[i]}) bad++;
        nvec++; if (to) begin nerr++; $display("FAIL small_timeout result_valid never rose"); end
        nvec++; if ({if0.grid_w, if0.grid_h} !== {16'd3, 16'd3}) begin nerr++; $display("FAIL small_dims got %0dx%0d want 3x3", if0.grid_w, if0.grid_h); end
        nvec++; if (got.size() != 1 || got[0] !== {16'd5, 16'd4, 16'd1, 16'd1}) begin nerr++; $display("FAIL small_request got n=%0d first=%h want 1 x 0005000400010001", got.size(), got.size() > 0 ? got[0] : '0); end
        nvec++; if (if0.result !== 64'd1) begin nerr++; $display("FAIL small_result got %0d want 1", if0.result); end
        nvec++; if (if0.busy !== 1'b0) begin nerr++; $display("FAIL small_busy got %b want 0", if0.busy); end
        nvec++; if (wlog.size() != 12 || bad != 0) begin nerr++; $display("FAIL small_writes got n=%0d bad=%0d want 12/0", wlog.size(), bad); end
        nvec++; if (req_bad(W, H) != 0) begin nerr++; $display("FAIL small_model got %0d bad requests want 0", req_bad(W, H)); end
    endtask

    task automatic test_raster();
        int W, H;
        bit to, sv;
        make_grid(10, 10, 0);
        start0(1, 0, 1);
        load0(0);
        #2;
        sv = if0.scan_valid;
        wait_done(to);
        model(W, H);
        nvec++; if (sv !== 1'b1) begin nerr++; $display("FAIL raster_first_valid got %b want 1", sv); end
        nvec++; if (to) begin nerr++; $display("FAIL raster_timeout result_valid never rose"); end
        nvec++; if ({if0.grid_w, if0.grid_h} !== {16'd10, 16'd10}) begin nerr++; $display("FAIL raster_dims got %0dx%0d want 10x10", if0.grid_w, if0.grid_h); end
        nvec++; if (got.size() != 64 || req_bad(W, H) != 0) begin nerr++; $display("FAIL raster_requests got n=%0d bad=%0d want 64/0", got.size(), req_bad(W, H)); end
        nvec++; if (if0.result !== 64'd32) begin nerr++; $display("FAIL raster_result got %0d want 32", if0.result); end
    endtask

    task automatic test_latency();
        int W, H;
        bit to;
        make_grid(10, 10, 1);
        start0(8, 0, 2);
        load0(1);
        wait_done(to);
        model(W, H);
        nvec++; if (to) begin nerr++; $display("FAIL latency_timeout result_valid never rose"); end
        nvec++; if (viol != 0) begin nerr++; $display("FAIL latency_max_out got %0d valid cycles at 4 outstanding want 0", viol); end
        nvec++; if (throttle == 0) begin nerr++; $display("FAIL latency_throttle got %0d throttled cycles want >0", throttle); end
        nvec++; if (got.size() != 64 || req_bad(W, H) != 0) begin nerr++; $display("FAIL latency_requests got n=%0d bad=%0d want 64/0", got.size(), req_bad(W, H)); end
        nvec++; if (if0.result !== 64'(exp_hits)) begin nerr++; $display("FAIL latency_result got %0d want %0d", if0.result, exp_hits); end
    endtask

    task automatic test_random_grids();
        for (int it = 0; it < 4; it++) begin
            int w, hh, W, H;
            bit to;
            w = $urandom_range(3, 12);
            hh = $urandom_range(3, 8);
            make_grid(w, hh, 1'($urandom_range(0, 1)));
            start0($urandom_range(1, 6), 1, 2);
            load0(1'($urandom_range(0, 1)));
            wait_done(to);
            model(W, H);
            nvec++; if (to) begin nerr++; $display("FAIL rnd%0d_timeout result_valid never rose", it); end
            nvec++; if ({if0.grid_w, if0.grid_h} !== {16'(W), 16'(H)}) begin nerr++; $display("FAIL rnd%0d_dims got %0dx%0d want %0dx%0d", it, if0.grid_w, if0.grid_h, W, H); end
            nvec++; if (req_bad(W, H) != 0) begin nerr++; $display("FAIL rnd%0d_requests got %0d bad of %0d want 0", it, req_bad(W, H), got.size()); end
            nvec++; if (stall_err != 0 || viol != 0) begin nerr++; $display("FAIL rnd%0d_stall got unstable=%0d over=%0d want 0/0", it, stall_err, viol); end
            nvec++; if (if0.result !== 64'(exp_hits)) begin nerr++; $display("FAIL rnd%0d_result got %0d want %0d", it, if0.result, exp_hits); end
        end
    endtask

    task automatic test_tiny();
        int n, W, H;
        set_str("ab\ncd\n");
        start0(1, 0, 0);
        load0(0);
        #2;
        n = 0;
        while (if0.result_valid !== 1'b1 && n < 2) begin
            @(negedge clk); #2; n++;
        end
        model(W, H);
        nvec++; if (if0.result_valid !== 1'b1) begin nerr++; $display("FAIL tiny_result_valid got %b want 1", if0.result_valid); end
        nvec++; if (if0.result !== 64'd0 || if0.busy !== 1'b0) begin nerr++; $display("FAIL tiny_result got %0d busy=%b want 0/0", if0.result, if0.busy); end
        nvec++; if (sv_seen != 0) begin nerr++; $display("FAIL tiny_no_scan got %0d valid cycles want 0", sv_seen); end
        nvec++; if ({if0.grid_w, if0.grid_h} !== {16'(W), 16'(H)}) begin nerr++; $display("FAIL tiny_dims got %0dx%0d want %0dx%0d", if0.grid_w, if0.grid_h, W, H); end
    endtask

    task automatic test_overflow();
        @(negedge clk); rst1 = 1;
        repeat (2) @(negedge clk);
        rst1 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if1.in_valid = 1;
            if1.in_byte = 8'($urandom_range(65, 90));
            if1.in_done = i == 19;
            if (i == 16) begin
                #2;
                nvec++; if ({if1.err_overflow, if1.busy} !== 2'b01) begin nerr++; $display("FAIL ovf_full_no_err got err=%b busy=%b want 0/1", if1.err_overflow, if1.busy); end
            end
        end
        @(negedge clk);
        if1.in_valid = 0; if1.in_done = 0;
        @(negedge clk); #2;
        nvec++; if (w1 != 16) begin nerr++; $display("FAIL ovf_writes got %0d want 16", w1); end
        nvec++; if ({if1.err_overflow, if1.result_valid, if1.busy} !== 3'b110) begin nerr++; $display("FAIL ovf_flags got err=%b rv=%b busy=%b want 1/1/0", if1.err_overflow, if1.result_valid, if1.busy); end
        nvec++; if (if1.result !== 64'd0 || sv1 != 0) begin nerr++; $display("FAIL ovf_result got %0d scans=%0d want 0/0", if1.result, sv1); end
    endtask

    task automatic test_reset_mid_scan();
        int n;
        bit to;
        make_grid(10, 10, 1);
        start0(8, 0, 2);
        load0(1);
        n = 0;
        while (n_acc < 10 && n < 500) begin
            @(negedge clk); #2; n++;
        end
        nvec++; if (n_acc < 10 || if0.busy !== 1'b1) begin nerr++; $display("FAIL midrst_reach_scan got acc=%0d busy=%b want >=10/1", n_acc, if0.busy); end
        @(negedge clk);
        rst0 = 1;
        #2;
        nvec++; if ({if0.scan_valid, if0.busy, if0.result_valid} !== 3'b0) begin nerr++; $display("FAIL midrst_flags got %b want 000", {if0.scan_valid, if0.busy, if0.result_valid}); end
        nvec++; if ({if0.result, if0.grid_w, if0.scan_addr, if0.scan_x} !== '0) begin nerr++; $display("FAIL midrst_values result=%0d w=%0d addr=%0d x=%0d want 0", if0.result, if0.grid_w, if0.scan_addr, if0.scan_x); end
        set_str("M.S\n.A.\nM.S\n");
        start0(1, 0, 0);
        load0(1);
        wait_done(to);
        nvec++; if (to || if0.result !== 64'd1 || got.size() != 1) begin nerr++; $display("FAIL midrst_reload got timeout=%b result=%0d n=%0d want 0/1/1", to, if0.result, got.size()); end
    endtask

    initial begin
        if0.in_valid = 0; if0.in_done = 0; if0.in_byte = 0;
        if1.in_valid = 0; if1.in_done = 0; if1.in_byte = 0;
        if1.scan_ready = 0; if1.hit_valid = 0; if1.hit = 0;
        test_reset();
        test_small();
        test_raster();
        test_latency();
        test_random_grids();
        test_tiny();
        test_overflow();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
